// File: rtl/live_edge_filter_pkg.sv
// rtl/live_edge_filter_pkg.sv - shared state encoding and default parameters for the LIVE gate filter
package live_edge_filter_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARM_ON  = 2'd1,
    ST_ON      = 2'd2,
    ST_ARM_OFF = 2'd3
  } live_state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_FILTER_LEN  = 16;

endpackage

// File: rtl/live_sync.sv
// rtl/live_sync.sv - multi-flop synchroniser for an asynchronous single-bit gate
module live_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/live_edge_filter.sv
// rtl/live_edge_filter.sv - LIVE gate synchroniser, glitch filter, edge strobes and spill length meter
module live_edge_filter
  import live_edge_filter_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int FILTER_LEN  = DEFAULT_FILTER_LEN,
  parameter int FILT_W      = 8,
  parameter int LEN_W       = 32,
  parameter int GLT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             live_in,
  output logic             live,
  output logic             live_rising,
  output logic             live_falling,
  output logic [LEN_W-1:0] spill_len,
  output logic             spill_len_valid,
  output logic [GLT_W-1:0] glitch_cnt
);

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN);
  localparam bit                FAST      = (FILTER_LEN == 1);

  logic              s;
  live_state_t       state;
  logic [FILT_W-1:0] fcnt;
  logic [LEN_W-1:0]  lcnt;
  logic [FILT_W-1:0] fcnt_inc;
  logic [LEN_W-1:0]  lcnt_inc;
  logic [GLT_W-1:0]  glitch_inc;

  live_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (live_in),
    .q     (s)
  );

  // Counters stick at all-ones instead of wrapping.
  assign fcnt_inc   = fcnt + 1'b1;
  assign lcnt_inc   = (&lcnt) ? lcnt : lcnt + 1'b1;
  assign glitch_inc = (&glitch_cnt) ? glitch_cnt : glitch_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_OFF;
      fcnt            <= '0;
      lcnt            <= '0;
      live            <= 1'b0;
      live_rising     <= 1'b0;
      live_falling    <= 1'b0;
      spill_len       <= '0;
      spill_len_valid <= 1'b0;
      glitch_cnt      <= '0;
    end else begin
      live_rising     <= 1'b0;
      live_falling    <= 1'b0;
      spill_len_valid <= 1'b0;
      case (state)
        ST_OFF: begin
          if (s && FAST) begin
            state       <= ST_ON;
            live        <= 1'b1;
            live_rising <= 1'b1;
            lcnt        <= '0;
          end else if (s) begin
            state <= ST_ARM_ON;
            fcnt  <= FILT_W'(1);
          end
        end
        ST_ARM_ON: begin
          if (!s) begin
            state      <= ST_OFF;
            glitch_cnt <= glitch_inc;
          end else if (fcnt_inc == FILT_LAST) begin
            state       <= ST_ON;
            live        <= 1'b1;
            live_rising <= 1'b1;
            lcnt        <= '0;
          end else begin
            fcnt <= fcnt_inc;
          end
        end
        ST_ON: begin
          lcnt <= lcnt_inc;
          if (!s && FAST) begin
            state           <= ST_OFF;
            live            <= 1'b0;
            live_falling    <= 1'b1;
            spill_len       <= lcnt_inc;
            spill_len_valid <= 1'b1;
          end else if (!s) begin
            state <= ST_ARM_OFF;
            fcnt  <= FILT_W'(1);
          end
        end
        ST_ARM_OFF: begin
          lcnt <= lcnt_inc;
          if (s) begin
            state      <= ST_ON;
            glitch_cnt <= glitch_inc;
          end else if (fcnt_inc == FILT_LAST) begin
            state           <= ST_OFF;
            live            <= 1'b0;
            live_falling    <= 1'b1;
            spill_len       <= lcnt_inc;
            spill_len_valid <= 1'b1;
          end else begin
            fcnt <= fcnt_inc;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_live_edge_filter.sv
// tb/tb_live_edge_filter.sv - self-checking bench for live_edge_filter
module tb_live_edge_filter;

  localparam int SYNC = 2;
  localparam int FL   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        live_in;
  logic        live, live_rising, live_falling, spill_len_valid;
  logic [31:0] spill_len;
  logic [15:0] glitch_cnt;

  logic        live_in2;
  logic        live2, rise2, fall2, valid2;
  logic [3:0]  spill_len2;
  logic [3:0]  glitch_cnt2;

  int tests = 0;
  int fails = 0;

  live_edge_filter #(.SYNC_STAGES(SYNC), .FILTER_LEN(FL), .FILT_W(8), .LEN_W(32), .GLT_W(16)) u_dut (
    .clk(clk), .reset(reset), .live_in(live_in), .live(live), .live_rising(live_rising),
    .live_falling(live_falling), .spill_len(spill_len), .spill_len_valid(spill_len_valid),
    .glitch_cnt(glitch_cnt)
  );

  live_edge_filter #(.SYNC_STAGES(SYNC), .FILTER_LEN(FL), .FILT_W(8), .LEN_W(4), .GLT_W(4)) u_small (
    .clk(clk), .reset(reset), .live_in(live_in2), .live(live2), .live_rising(rise2),
    .live_falling(fall2), .spill_len(spill_len2), .spill_len_valid(valid2),
    .glitch_cnt(glitch_cnt2)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference: the filtered level flips once the last FL synchronised samples all
  // disagree with it; a disagreeing run that ends early is a glitch.
  bit          lin_q[$];
  bit          s_q[$];
  bit          m_live = 1'b0;
  int          m_rise = 0, m_fall = 0, m_glitch = 0, m_edge = 0, m_rise_edge = 0;
  logic [31:0] m_spills[$];

  always @(posedge clk or posedge reset) begin
    bit s_now, all_diff;
    if (reset) begin
      lin_q.delete();
      s_q.delete();
      m_live   = 1'b0;
      m_glitch = 0;
    end else begin
      m_edge++;
      lin_q.push_back(live_in);
      s_now = (lin_q.size() > SYNC) ? lin_q[lin_q.size()-1-SYNC] : 1'b0;
      s_q.push_back(s_now);
      all_diff = (s_q.size() >= FL);
      if (all_diff)
        for (int i = 0; i < FL; i++)
          if (s_q[s_q.size()-1-i] == m_live) all_diff = 1'b0;
      if (all_diff) begin
        m_live = !m_live;
        if (m_live) begin
          m_rise++;
          m_rise_edge = m_edge;
        end else begin
          m_fall++;
          m_spills.push_back(32'(m_edge - m_rise_edge));
        end
      end else if (s_q.size() >= 2 && s_q[s_q.size()-2] != m_live && s_now == m_live) begin
        if (m_glitch < 65535) m_glitch++;
      end
      if (lin_q.size() > 16) void'(lin_q.pop_front());
      if (s_q.size() > 16) void'(s_q.pop_front());
    end
  end

  int          d_rise = 0, d_fall = 0, d_valid = 0, d_both = 0, d_live_mis = 0;
  int          d_rise_edge = 0, d_fall_edge = 0, s_valid = 0;
  logic [31:0] d_spills[$];

  always @(negedge clk) begin
    if (live_rising) begin d_rise++; d_rise_edge = edge_n; end
    if (live_falling) begin d_fall++; d_fall_edge = edge_n; end
    if (live_rising && live_falling) d_both++;
    if (spill_len_valid) begin d_valid++; d_spills.push_back(spill_len); end
    if (live !== m_live) d_live_mis++;
    if (valid2) s_valid++;
  end

  task automatic clear_counts();
    d_rise = 0; d_fall = 0; d_valid = 0; d_both = 0; d_live_mis = 0;
    d_spills.delete();
  endtask

  task automatic pulse(input int hi, input int lo, output int t0);
    @(posedge clk); #1;
    t0 = edge_n;
    live_in = 1'b1;
    repeat (hi) @(posedge clk);
    #1 live_in = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_counts();
    repeat (20) @(posedge clk);
    #1;
    tests++; if (live !== 1'b0) begin fails++; $display("FAIL reset_live got %0b expected 0", live); end
    tests++; if (d_rise + d_fall + d_valid != 0) begin fails++; $display("FAIL reset_strobes got %0d expected 0", d_rise + d_fall + d_valid); end
    tests++; if (glitch_cnt !== 16'd0) begin fails++; $display("FAIL reset_glitch got %0d expected 0", glitch_cnt); end
    tests++; if (spill_len !== 32'd0) begin fails++; $display("FAIL reset_spill_len got %0d expected 0", spill_len); end
  endtask

  task automatic test_clean_spill();
    int t0;
    clear_counts();
    pulse(100, 30, t0);
    tests++; if (d_rise != 1 || d_rise_edge != t0 + 6) begin fails++; $display("FAIL clean_rise got n=%0d edge=%0d expected n=1 edge=%0d", d_rise, d_rise_edge - t0, 6); end
    tests++; if (d_fall != 1 || d_fall_edge != t0 + 106) begin fails++; $display("FAIL clean_fall got n=%0d edge=%0d expected n=1 edge=%0d", d_fall, d_fall_edge - t0, 106); end
    tests++; if (d_valid != 1 || spill_len !== 32'd100) begin fails++; $display("FAIL clean_len got n=%0d len=%0d expected n=1 len=100", d_valid, spill_len); end
    tests++; if (glitch_cnt !== 16'd0 || d_both != 0) begin fails++; $display("FAIL clean_glitch got %0d both=%0d expected 0", glitch_cnt, d_both); end
  endtask

  task automatic test_short_pulse();
    int t0;
    logic [15:0] g0;
    g0 = glitch_cnt;
    clear_counts();
    pulse(3, 20, t0);
    tests++; if (d_rise + d_fall != 0 || live !== 1'b0) begin fails++; $display("FAIL short3_strobes got %0d live=%0b expected 0", d_rise + d_fall, live); end
    tests++; if (glitch_cnt !== g0 + 16'd1) begin fails++; $display("FAIL short3_glitch got %0d expected %0d", glitch_cnt, g0 + 16'd1); end
    pulse(4, 20, t0);
    tests++; if (d_rise != 1 || d_fall != 1) begin fails++; $display("FAIL min4_strobes got rise=%0d fall=%0d expected 1/1", d_rise, d_fall); end
    tests++; if (spill_len !== 32'd4) begin fails++; $display("FAIL min4_len got %0d expected 4", spill_len); end
  endtask

  task automatic test_dropout();
    logic [15:0] g0;
    g0 = glitch_cnt;
    clear_counts();
    @(posedge clk); #1 live_in = 1'b1;
    repeat (100) @(posedge clk);
    #1 live_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 live_in = 1'b1;
    repeat (97) @(posedge clk);
    #1 live_in = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    tests++; if (d_fall != 1 || d_valid != 1) begin fails++; $display("FAIL dropout_falls got %0d/%0d expected 1/1", d_fall, d_valid); end
    tests++; if (glitch_cnt !== g0 + 16'd1) begin fails++; $display("FAIL dropout_glitch got %0d expected %0d", glitch_cnt, g0 + 16'd1); end
    tests++; if (spill_len !== 32'd200) begin fails++; $display("FAIL dropout_len got %0d expected 200", spill_len); end
  endtask

  task automatic test_reset_mid_spill();
    int t0;
    clear_counts();
    @(posedge clk); #1 live_in = 1'b1;
    repeat (50) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    tests++; if ({live, live_rising, live_falling, spill_len_valid} !== 4'b0 || spill_len !== 32'd0 || glitch_cnt !== 16'd0)
      begin fails++; $display("FAIL async_reset got live=%0b len=%0d glitch=%0d expected all 0", live, spill_len, glitch_cnt); end
    live_in = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests++; if (d_fall != 0 || d_valid != 0) begin fails++; $display("FAIL reset_no_fall got %0d/%0d expected 0/0", d_fall, d_valid); end
    pulse(30, 20, t0);
    tests++; if (d_valid != 1 || spill_len !== 32'd30) begin fails++; $display("FAIL post_reset_len got n=%0d len=%0d expected n=1 len=30", d_valid, spill_len); end
  endtask

  task automatic test_random();
    int r0, f0;
    bit lvl;
    clear_counts();
    m_spills.delete();
    r0 = m_rise; f0 = m_fall;
    lvl = 1'b0;
    for (int seg = 0; seg < 60; seg++) begin
      lvl = !lvl;
      @(posedge clk); #1 live_in = lvl;
      repeat ($urandom_range(0, 11)) @(posedge clk);
    end
    @(posedge clk); #1 live_in = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    tests++; if (d_rise != m_rise - r0) begin fails++; $display("FAIL rand_rise got %0d expected %0d", d_rise, m_rise - r0); end
    tests++; if (d_fall != m_fall - f0) begin fails++; $display("FAIL rand_fall got %0d expected %0d", d_fall, m_fall - f0); end
    tests++; if (glitch_cnt !== 16'(m_glitch)) begin fails++; $display("FAIL rand_glitch got %0d expected %0d", glitch_cnt, m_glitch); end
    tests++; if (d_live_mis != 0 || d_both != 0) begin fails++; $display("FAIL rand_live got %0d mismatching cycles, %0d double strobes, expected 0", d_live_mis, d_both); end
    tests++; if (d_spills.size() != m_spills.size()) begin fails++; $display("FAIL rand_nspills got %0d expected %0d", d_spills.size(), m_spills.size()); end
    for (int i = 0; i < d_spills.size() && i < m_spills.size(); i++) begin
      tests++; if (d_spills[i] !== m_spills[i]) begin fails++; $display("FAIL rand_len[%0d] got %0d expected %0d", i, d_spills[i], m_spills[i]); end
    end
  endtask

  task automatic test_saturation();
    s_valid = 0;
    @(posedge clk); #1 live_in2 = 1'b1;
    repeat (20) @(posedge clk);
    #1 live_in2 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests++; if (s_valid != 1 || spill_len2 !== 4'hF) begin fails++; $display("FAIL sat_len got n=%0d len=%0d expected n=1 len=15", s_valid, spill_len2); end
    for (int g = 0; g < 18; g++) begin
      @(posedge clk); #1 live_in2 = 1'b1;
      repeat (3) @(posedge clk);
      #1 live_in2 = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      if (g == 13) begin
        tests++; if (glitch_cnt2 !== 4'd14) begin fails++; $display("FAIL glitch14 got %0d expected 14", glitch_cnt2); end
      end
    end
    tests++; if (glitch_cnt2 !== 4'hF || live2 !== 1'b0) begin fails++; $display("FAIL sat_glitch got %0d live=%0b expected 15 live=0", glitch_cnt2, live2); end
  endtask

  initial begin
    reset = 1'b1; live_in = 1'b0; live_in2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (live !== 1'b0 || glitch_cnt !== 16'd0 || spill_len !== 32'd0) begin fails++; $display("FAIL in_reset got live=%0b glitch=%0d len=%0d expected 0", live, glitch_cnt, spill_len); end
    reset = 1'b0;
    test_reset();
    test_clean_spill();
    test_short_pulse();
    test_dropout();
    test_reset_mid_spill();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
